// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter bundle for uart_tx_arb; the req_last packet marker exists only
// when UART_ARB_LOCK_EN is defined.
interface uart_tx_arb_if #(
  parameter int N_REQ        = 4,
  parameter int PAYLOAD_BITS = 8
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ*PAYLOAD_BITS-1:0] req_data;
  logic [N_REQ-1:0]              req_ready;
  logic                          uart_tx_en;
  logic [PAYLOAD_BITS-1:0]       uart_tx_data;
  logic                          uart_tx_busy;
  logic [IDW-1:0]                grant_id;
  logic                          arb_busy;
  logic                          err_timeout;
  logic [15:0]                   frames_sent;
`ifdef UART_ARB_LOCK_EN
  logic [N_REQ-1:0]              req_last;

  modport master (output req_valid, req_data, req_last, uart_tx_busy,
                  input  req_ready, uart_tx_en, uart_tx_data, grant_id,
                         arb_busy, err_timeout, frames_sent);
  modport slave  (input  req_valid, req_data, req_last, uart_tx_busy,
                  output req_ready, uart_tx_en, uart_tx_data, grant_id,
                         arb_busy, err_timeout, frames_sent);
`else
  modport master (output req_valid, req_data, uart_tx_busy,
                  input  req_ready, uart_tx_en, uart_tx_data, grant_id,
                         arb_busy, err_timeout, frames_sent);
  modport slave  (input  req_valid, req_data, uart_tx_busy,
                  output req_ready, uart_tx_en, uart_tx_data, grant_id,
                         arb_busy, err_timeout, frames_sent);
`endif
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Define UART_ARB_LOCK_EN to keep multi-byte packets (closed by req_last) uninterleaved.
module uart_tx_arb #(
  parameter int N_REQ        = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUSY_TIMEOUT = 8
) (
  input logic          clk,
  input logic          reset,
  uart_tx_arb_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  r_state, w_stateNext;
  logic [IDW-1:0]          r_ptr, r_grant, w_winner;
  logic [PAYLOAD_BITS-1:0] r_dataQ;
  logic                    r_txEn, r_err;
  logic [CW-1:0]           r_cnt;
  logic [15:0]             r_frames;
  logic [N_REQ-1:0]        w_cand, w_ready;
  logic                    w_found, w_accept, w_timeoutHit, w_frameDone;

`ifdef UART_ARB_LOCK_EN
  logic r_lock;
  assign w_cand = r_lock ? (bus.req_valid & (N_REQ'(1) << r_grant)) : bus.req_valid;
`else
  assign w_cand = bus.req_valid;
`endif

  // First candidate found searching upward from the slot after the last winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && w_cand[(int'(r_ptr) + k) % N_REQ]) begin
        w_found  = 1'b1;
        w_winner = IDW'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_ready      = '0;
    w_accept     = 1'b0;
    w_timeoutHit = 1'b0;
    w_frameDone  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && !bus.uart_tx_busy) begin
          w_ready[w_winner] = 1'b1;
          w_accept          = 1'b1;
          w_stateNext       = ISSUE;
        end
      end
      ISSUE: w_stateNext = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.uart_tx_busy) begin
          w_stateNext = WAIT_DONE;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 2)) begin
          w_timeoutHit = 1'b1;
          w_stateNext  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_tx_busy) begin
          w_frameDone = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Strobe and error pulse are registered so both land one cycle after their decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txEn   <= 1'b0;
      r_err    <= 1'b0;
      r_dataQ  <= '0;
      r_grant  <= '0;
      r_ptr    <= IDW'(N_REQ - 1);
      r_cnt    <= '0;
      r_frames <= '0;
`ifdef UART_ARB_LOCK_EN
      r_lock   <= 1'b0;
`endif
    end else begin
      r_txEn <= w_accept;
      r_err  <= w_timeoutHit;
      if (w_accept) begin
        r_dataQ <= bus.req_data[int'(w_winner)*PAYLOAD_BITS +: PAYLOAD_BITS];
        r_grant <= w_winner;
        r_ptr   <= w_winner;
`ifdef UART_ARB_LOCK_EN
        r_lock  <= !bus.req_last[w_winner];
`endif
      end
`ifdef UART_ARB_LOCK_EN
      if (w_timeoutHit) r_lock <= 1'b0;
`endif
      if (r_state == ISSUE)
        r_cnt <= '0;
      else if (r_state == WAIT_BUSY && !bus.uart_tx_busy)
        r_cnt <= r_cnt + CW'(1);
      if (w_frameDone) r_frames <= r_frames + 16'd1;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.uart_tx_en   = r_txEn;
  assign bus.uart_tx_data = r_dataQ;
  assign bus.grant_id     = r_grant;
  assign bus.arb_busy     = (r_state != IDLE);
  assign bus.err_timeout  = r_err;
  assign bus.frames_sent  = r_frames;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: vector table, directed corner sequences and a
// randomized run against a timeline model of accept/issue/frame-done events.
module tb_uart_tx_arb;
  localparam int N  = 4;
  localparam int PB = 8;
  localparam int BT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(N), .PAYLOAD_BITS(PB)) bus ();

  uart_tx_arb #(.N_REQ(N), .PAYLOAD_BITS(PB), .BUSY_TIMEOUT(BT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Timeline model: absolute cycle numbers at which each visible event is due.
  int       mFreeAt, mEnAt, mErrAt, mFrameAt, mBusyLo, mBusyHi, mAccAt, mFrames, mWin;
  int       mPtr, mGrant;
  logic [7:0] mData;
  bit       mLock, mAcc;

  logic [7:0] obsData[$];
  int       obsGrant[$];
  int       gapQ[$];
  int       enCyc, errCyc, errPulses, readyPulses, fallCyc;
  bit       prevBusy, lastEn;
  logic [3:0] lastReady;
  int       lastGrant;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mFreeAt = 0; mEnAt = -1; mErrAt = -1; mFrameAt = -1;
    mBusyLo = 1; mBusyHi = 0; mAccAt = -1; mFrames = 0;
    mPtr = N - 1; mGrant = 0; mData = 8'h00; mLock = 1'b0; mAcc = 1'b0; mWin = 0;
    prevBusy = 1'b0; fallCyc = 0;
  endtask

  task automatic clearObs();
    obsData.delete(); obsGrant.delete(); gapQ.delete();
    errPulses = 0; readyPulses = 0; enCyc = 0; errCyc = 0;
  endtask

  task automatic applyReset(input bit holdBusy);
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.uart_tx_busy = holdBusy;
`ifdef UART_ARB_LOCK_EN
    bus.req_last = '0;
`endif
    @(negedge clk);
    #1;
    checkOutput("rst_arb_busy", bus.arb_busy, 0);
    checkOutput("rst_tx_en", bus.uart_tx_en, 0);
    checkOutput("rst_frames", bus.frames_sent, 0);
    checkOutput("rst_err", bus.err_timeout, 0);
    checkOutput("rst_grant", bus.grant_id, 0);
    checkOutput("rst_data", bus.uart_tx_data, 0);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic [3:0] last,
                               input int busyLen, input bit noBusy, input bit forceBusy);
    logic [3:0] cand, expReady;
    bit busyIn;
    int idx;
    @(negedge clk);
    cyc++;
    if (cyc == mFrameAt) mFrames++;
    busyIn = forceBusy || (cyc >= mBusyLo && cyc <= mBusyHi);
    bus.req_valid = v;
    bus.req_data = d;
    bus.uart_tx_busy = busyIn;
`ifdef UART_ARB_LOCK_EN
    bus.req_last = last;
`endif
    #1;
    cand = v;
`ifdef UART_ARB_LOCK_EN
    if (mLock) cand = v & (4'b0001 << mGrant);
`endif
    mAcc = 1'b0; mWin = 0; expReady = '0;
    if (cyc >= mFreeAt && !busyIn) begin
      for (int k = 1; k <= N; k++) begin
        idx = (mPtr + k) % N;
        if (!mAcc && cand[idx]) begin mAcc = 1'b1; mWin = idx; end
      end
    end
    if (mAcc) expReady[mWin] = 1'b1;
    checkOutput("ready", bus.req_ready, expReady);
    checkOutput("tx_en", bus.uart_tx_en, (cyc == mEnAt));
    checkOutput("tx_data", bus.uart_tx_data, mData);
    checkOutput("grant_id", bus.grant_id, mGrant);
    checkOutput("err_timeout", bus.err_timeout, (cyc == mErrAt));
    checkOutput("frames_sent", bus.frames_sent, 16'(mFrames));
    checkOutput("arb_busy", bus.arb_busy, (cyc > mAccAt && cyc < mFreeAt));
    if (prevBusy && !busyIn) fallCyc = cyc;
    prevBusy = busyIn;
    if (bus.uart_tx_en) begin
      obsData.push_back(bus.uart_tx_data);
      obsGrant.push_back(int'(bus.grant_id));
      enCyc = cyc;
    end
    if (bus.err_timeout) begin errPulses++; errCyc = cyc; end
    if (|bus.req_ready) begin readyPulses++; gapQ.push_back(cyc - fallCyc); end
    lastReady = bus.req_ready;
    lastEn = bus.uart_tx_en;
    lastGrant = int'(bus.grant_id);
    if (mAcc) begin
      mPtr = mWin; mGrant = mWin; mData = d[mWin*8 +: 8];
      mEnAt = cyc + 1; mAccAt = cyc;
      if (noBusy) begin
        mErrAt = cyc + 1 + BT; mFreeAt = cyc + 1 + BT; mLock = 1'b0;
      end else begin
        mBusyLo = cyc + 2; mBusyHi = cyc + 1 + busyLen;
        mFrameAt = cyc + 3 + busyLen; mFreeAt = mFrameAt;
`ifdef UART_ARB_LOCK_EN
        mLock = !last[mWin];
`endif
      end
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] expReady;
    int         expGrant;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [7:0] rotExp[5];
    logic [3:0] rv, lastIn;
    logic [31:0] rd;
    int n;

    vecs[0] = '{4'b0001, 4'b0001, 0};
    vecs[1] = '{4'b0110, 4'b0010, 1};
    vecs[2] = '{4'b1000, 4'b1000, 3};
    vecs[3] = '{4'b1100, 4'b0100, 2};
    vecs[4] = '{4'b0000, 4'b0000, 0};
    vecs[5] = '{4'b1111, 4'b0001, 0};
    vecs[6] = '{4'b1010, 4'b0010, 1};
    rotExp = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

    bus.req_valid = '0;
    bus.req_data = '0;
    bus.uart_tx_busy = 1'b0;
`ifdef UART_ARB_LOCK_EN
    bus.req_last = '0;
`endif
    modelReset();
    clearObs();

    // Priority from reset: pointer starts at N_REQ-1, so the lowest valid index wins.
    foreach (vecs[i]) begin
      applyReset(1'b0);
      applyStimulus(vecs[i].valid, 32'h44332211, 4'hF, 2, 1'b0, 1'b0);
      checkOutput("tbl_ready", lastReady, vecs[i].expReady);
      applyStimulus(4'h0, 32'h0, 4'hF, 2, 1'b0, 1'b0);
      checkOutput("tbl_en", lastEn, (vecs[i].expReady != 0));
      checkOutput("tbl_grant", lastGrant, vecs[i].expGrant);
    end

    // All requesters valid, 10-cycle frames: grants rotate.
    applyReset(1'b0);
    clearObs();
    for (int i = 0; i < 62; i++) applyStimulus(4'hF, 32'h43322110, 4'hF, 10, 1'b0, 1'b0);
    checkOutput("rot_count", (obsData.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      if (i < obsData.size()) checkOutput("rot_data", obsData[i], rotExp[i]);

    // Single requester granted back-to-back.
    applyReset(1'b0);
    clearObs();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus((n < 3) ? 4'b0100 : 4'b0000, 32'h00A00000 | (n << 16), 4'hF, 4, 1'b0, 1'b0);
      if (mAcc) n++;
    end
    checkOutput("single_frames", bus.frames_sent, 3);
    checkOutput("single_count", obsGrant.size(), 3);
    foreach (obsGrant[i]) checkOutput("single_grant", obsGrant[i], 2);
    for (int i = 1; i < 3; i++)
      if (i < gapQ.size()) checkOutput("single_gap", gapQ[i], 1);

    // Transmitter never goes busy.
    applyReset(1'b0);
    clearObs();
    applyStimulus(4'b0001, 32'h0000005A, 4'hF, 0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(4'h0, 32'h0, 4'hF, 0, 1'b0, 1'b0);
    checkOutput("to_pulses", errPulses, 1);
    checkOutput("to_delay", errCyc - enCyc, BT);
    checkOutput("to_frames", bus.frames_sent, 0);
    checkOutput("to_idle", bus.arb_busy, 0);

    // Reset mid-frame with the transmitter still busy.
    applyReset(1'b0);
    applyStimulus(4'b0001, 32'h00000077, 4'hF, 30, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(4'h0, 32'h0, 4'hF, 30, 1'b0, 1'b0);
    checkOutput("mid_wait_done", bus.arb_busy, 1);
    applyReset(1'b1);
    clearObs();
    for (int i = 0; i < 5; i++) applyStimulus(4'hF, 32'h43322110, 4'hF, 3, 1'b0, 1'b1);
    checkOutput("busy_hold_ready", readyPulses, 0);
    applyStimulus(4'hF, 32'h43322110, 4'hF, 3, 1'b0, 1'b0);
    checkOutput("busy_release_ready", lastReady, 4'b0001);
    applyStimulus(4'h0, 32'h0, 4'hF, 3, 1'b0, 1'b0);
    checkOutput("busy_release_data", (obsData.size() > 0) ? obsData[0] : 8'hXX, 8'h10);
    checkOutput("busy_release_frames", bus.frames_sent, 0);

`ifdef UART_ARB_LOCK_EN
    // Requester 0 sends a 3-byte packet while requester 1 waits.
    applyReset(1'b0);
    clearObs();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus({2'b00, 1'b1, (n < 3)}, 32'h00003130 | (n & 32'hF), (n == 2) ? 4'b0011 : 4'b0010,
                    2, 1'b0, 1'b0);
      if (mAcc && mWin == 0) n++;
    end
    checkOutput("lock_count", (obsGrant.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      if (i < obsGrant.size()) checkOutput("lock_grant", obsGrant[i], (i < 3) ? 0 : 1);
`endif

    // Randomized traffic against the timeline model.
    applyReset(1'b0);
    rv = '0;
    rd = '0;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        if (rv[r] && mAcc && mWin == r) begin
          rv[r] = 1'($urandom_range(0, 1));
          rd[r*8 +: 8] = 8'($urandom);
        end else if (!rv[r]) begin
          rv[r] = ($urandom_range(0, 3) == 0);
          rd[r*8 +: 8] = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          rv[r] = 1'b0;
        end
      end
      lastIn = 4'($urandom);
      applyStimulus(rv, rd, lastIn, $urandom_range(1, 6), ($urandom_range(0, 5) == 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
